// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: memory-mapped register
// addresses, STATUS bit positions, the address-region type and a byte-lane
// merge helper.
package dmem_pkg;

    localparam logic [31:0] LED_ADDR    = 32'hFFFF_0000;
    localparam logic [31:0] CYCLE_ADDR  = 32'hFFFF_0004;
    localparam logic [31:0] STATUS_ADDR = 32'hFFFF_0008;

    localparam int STATUS_DONE_BIT    = 0;
    localparam int STATUS_PASS_BIT    = 1;
    localparam int STATUS_TIMEOUT_BIT = 2;
    localparam int STATUS_BUS_ERR_BIT = 3;

    typedef enum logic [2:0] {
        REGION_RAM,
        REGION_LED,
        REGION_CYCLE,
        REGION_STATUS,
        REGION_NONE
    } region_e;

    // Replace the byte lanes of old_word selected by strobe with those of new_word.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strobe);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strobe[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// Word-wide RAM with per-byte write enables: synchronous write, asynchronous
// read. Contents are deliberately not reset.
module dmem_bram #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wd,
    output logic [31:0]   rd
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane write: each enabled lane of the addressed word takes wd.
    // NOTE: the array has no reset branch; resetting a memory turns it into
    // thousands of flops instead of a RAM macro, and software never relies on it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    assign rd = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-side responder for the single-cycle core: byte-strobed RAM, LED/result
// register, free-running cycle counter and sticky pass/fail/timeout/bus-error
// flags readable through a STATUS register.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int TIMEOUT     = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic        WE,
    input  logic [3:0]  Strobe,
    output logic [31:0] RD,
    output logic [31:0] led,
    output logic        test_done,
    output logic        test_pass,
    output logic        timeout,
    output logic        bus_err
);

    import dmem_pkg::*;

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [31:0] WATCH_AT  = 32'(TIMEOUT - 1);

    region_e     region;
    logic        wr_en;
    logic        led_wr;
    logic [3:0]  ram_be;
    logic [31:0] ram_rd;
    logic [31:0] cycle;
    logic [31:0] status_word;

    // Address decode; the low two address bits never affect the region.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        region = REGION_NONE;
        if (Addr < RAM_BYTES) begin
            region = REGION_RAM;
        end else if (Addr[31:2] == LED_ADDR[31:2]) begin
            region = REGION_LED;
        end else if (Addr[31:2] == CYCLE_ADDR[31:2]) begin
            region = REGION_CYCLE;
        end else if (Addr[31:2] == STATUS_ADDR[31:2]) begin
            region = REGION_STATUS;
        end
    end

    // A write happens only with at least one lane enabled; reset kills it.
    assign wr_en  = WE && (Strobe != 4'b0000);
    assign led_wr = wr_en && (region == REGION_LED);
    assign ram_be = (wr_en && !rst && region == REGION_RAM) ? Strobe : 4'b0000;

    dmem_bram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bram (
        .clk  (clk),
        .be   (ram_be),
        .addr (Addr[AW+1:2]),
        .wd   (WD),
        .rd   (ram_rd)
    );

    // Free-running cycle counter, wraps naturally at 2^32.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle <= 32'd0;
        end else begin
            cycle <= cycle + 32'd1;
        end
    end

    // LED register and sticky result flags; the first LED write latches the verdict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led       <= 32'd0;
            test_done <= 1'b0;
            test_pass <= 1'b0;
        end else if (led_wr) begin
            led <= lane_merge(led, WD, Strobe);
            if (!test_done) begin
                test_done <= 1'b1;
                test_pass <= (WD == 32'h0000_0001);
            end
        end
    end

    // Watchdog and bus-error flags; a result write on the watchdog edge wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            if (cycle == WATCH_AT && !test_done && !led_wr) begin
                timeout <= 1'b1;
            end
            if (wr_en && region == REGION_NONE) begin
                bus_err <= 1'b1;
            end
        end
    end

    // STATUS word assembled from the sticky flags.
    always_comb begin
        status_word                     = 32'd0;
        status_word[STATUS_DONE_BIT]    = test_done;
        status_word[STATUS_PASS_BIT]    = test_pass;
        status_word[STATUS_TIMEOUT_BIT] = timeout;
        status_word[STATUS_BUS_ERR_BIT] = bus_err;
    end

    // Zero-latency read mux; unmapped addresses read as zero.
    always_comb begin
        RD = 32'd0;
        case (region)
            REGION_RAM:    RD = ram_rd;
            REGION_LED:    RD = led;
            REGION_CYCLE:  RD = cycle;
            REGION_STATUS: RD = status_word;
            default:       RD = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a behavioural model of the memory
// map checked against the DUT every cycle, plus directed scenarios with
// hand-computed expectations (strobes, pass/fail, watchdog, bus error, reset).
`timescale 1ns/1ps
module tb_dmem_responder;

    import dmem_pkg::*;

    localparam int DEPTH = 256;
    localparam int TMO   = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] Addr = 32'd0;
    logic [31:0] WD = 32'd0;
    logic        WE = 1'b0;
    logic [3:0]  Strobe = 4'd0;
    logic [31:0] RD;
    logic [31:0] led;
    logic        test_done, test_pass, timeout, bus_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .TIMEOUT     (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Addr      (Addr),
        .WD        (WD),
        .WE        (WE),
        .Strobe    (Strobe),
        .RD        (RD),
        .led       (led),
        .test_done (test_done),
        .test_pass (test_pass),
        .timeout   (timeout),
        .bus_err   (bus_err)
    );

    always #50 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_ram [DEPTH];
    logic [31:0] m_led = 32'd0;
    logic [31:0] m_cycle = 32'd0;
    logic        m_done = 1'b0, m_pass = 1'b0, m_tmo = 1'b0, m_berr = 1'b0;

    // 0 = RAM, 1 = LED, 2 = CYCLE, 3 = STATUS, 4 = unmapped
    function automatic int region_of(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (a < 32'(4 * DEPTH)) return 0;
        if (w == LED_ADDR)      return 1;
        if (w == CYCLE_ADDR)    return 2;
        if (w == STATUS_ADDR)   return 3;
        return 4;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        case (region_of(a))
            0:       return m_ram[a[9:2]];
            1:       return m_led;
            2:       return m_cycle;
            3:       return {28'd0, m_berr, m_tmo, m_pass, m_done};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_led   <= 32'd0;
            m_cycle <= 32'd0;
            m_done  <= 1'b0;
            m_pass  <= 1'b0;
            m_tmo   <= 1'b0;
            m_berr  <= 1'b0;
        end else begin
            m_cycle <= m_cycle + 32'd1;
            if (WE && Strobe != 4'd0) begin
                case (region_of(Addr))
                    0: m_ram[Addr[9:2]] <= merge(m_ram[Addr[9:2]], WD, Strobe);
                    1: begin
                        m_led <= merge(m_led, WD, Strobe);
                        if (!m_done) begin
                            m_done <= 1'b1;
                            m_pass <= (WD == 32'd1);
                        end
                    end
                    4: m_berr <= 1'b1;
                    default: ;
                endcase
            end
            if (m_cycle == 32'(TMO - 1) && !m_done &&
                !(WE && Strobe != 4'd0 && region_of(Addr) == 1))
                m_tmo <= 1'b1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] flags();
        return {28'd0, bus_err, timeout, test_pass, test_done};
    endfunction

    // Every cycle out of reset: outputs must match the model.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("cmp_led", led, m_led);
            check("cmp_flags", flags(), {28'd0, m_berr, m_tmo, m_pass, m_done});
            if (!$isunknown(model_rd(Addr)))
                check("cmp_rd", RD, model_rd(Addr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        Addr = a; WD = d; Strobe = s; WE = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        WE = 1'b0; Strobe = 4'd0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        Addr = a; WE = 1'b0; Strobe = 4'd0;
        #1;
        check(name, RD, exp);
    endtask

    task automatic do_reset();
        WE = 1'b0; Strobe = 4'd0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running, expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        #1;
        do_reset();
        cmp_en = 1'b1;

        // Reset state (cycle 0)
        check("rst_led", led, 32'd0);
        check("rst_flags", flags(), 32'd0);
        rd_chk("rst_cycle", CYCLE_ADDR, 32'd0);
        rd_chk("rst_status", STATUS_ADDR, 32'd0);
        rd_chk("rst_unmapped", 32'h8000_0000, 32'd0);

        // RAM byte strobes, ignored low address bits, top word of RAM
        wr(32'h10, 32'hAABB_CCDD, 4'b1111);
        wr(32'h10, 32'h1122_3344, 4'b0101);
        wr(32'h22, 32'h1234_5678, 4'b1111);
        wr(32'h3FC, 32'hCAFE_F00D, 4'b1111);
        rd_chk("ram_strobe", 32'h10, 32'hAA22_CC44);
        rd_chk("ram_lowbits", 32'h20, 32'h1234_5678);
        rd_chk("ram_top", 32'h3FC, 32'hCAFE_F00D);

        // Read-only CYCLE write: no bus error, counter unaffected (5 edges)
        wr(CYCLE_ADDR, 32'd0, 4'b1111);
        check("cycle_wr_no_berr", {31'd0, bus_err}, 32'd0);
        rd_chk("cycle_wr_ignored", CYCLE_ADDR, 32'd5);

        // Zero-strobe writes do nothing (7 edges)
        wr(32'h400, 32'hFFFF, 4'b0000);
        wr(LED_ADDR, 32'hFFFF_FFFF, 4'b0000);
        check("zero_strobe_flags", flags(), 32'd0);
        check("zero_strobe_led", led, 32'd0);

        // Pass path: first LED write of 1 on edge 20
        idle(12);
        wr(LED_ADDR, 32'd1, 4'b1111);
        check("pass_flags", flags(), 32'h3);
        check("pass_led", led, 32'd1);
        rd_chk("pass_cycle", CYCLE_ADDR, 32'd20);
        wr(LED_ADDR, 32'd2, 4'b1111);
        check("later_led", led, 32'd2);
        rd_chk("later_status", STATUS_ADDR, 32'h3);
        wr(LED_ADDR, 32'h0000_AB00, 4'b0010);
        check("led_strobe", led, 32'h0000_AB02);

        // Unmapped write
        wr(32'h8000_0000, 32'hDEAD_BEEF, 4'b1111);
        check("berr_set", {31'd0, bus_err}, 32'd1);
        rd_chk("berr_rd_zero", 32'h8000_0000, 32'd0);
        rd_chk("berr_status", STATUS_ADDR, 32'hB);

        // Asynchronous reset between edges, with a RAM write in flight
        Addr = 32'h10; WD = 32'd0; Strobe = 4'b1111; WE = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check("async_led", led, 32'd0);
        check("async_flags", flags(), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        WE = 1'b0; Strobe = 4'd0; rst = 1'b0;
        rd_chk("async_ram_kept", 32'h10, 32'hAA22_CC44);
        rd_chk("async_cycle0", CYCLE_ADDR, 32'd0);
        idle(3);
        rd_chk("async_cycle3", CYCLE_ADDR, 32'd3);
        rd_chk("async_ram_top", 32'h3FC, 32'hCAFE_F00D);

        // Watchdog fires after edge 50; late result still sets done/pass
        do_reset();
        idle(49);
        check("wd_before", {31'd0, timeout}, 32'd0);
        rd_chk("wd_cycle49", CYCLE_ADDR, 32'd49);
        idle(1);
        check("wd_fired", {31'd0, timeout}, 32'd1);
        rd_chk("wd_cycle50", CYCLE_ADDR, 32'd50);
        rd_chk("wd_status", STATUS_ADDR, 32'h4);
        wr(LED_ADDR, 32'd1, 4'b0010);
        check("wd_late_flags", flags(), 32'h7);
        check("wd_late_led", led, 32'd0);

        // Result write on the watchdog edge wins; fail verdict; RAM boundary
        do_reset();
        idle(49);
        wr(LED_ADDR, 32'd2, 4'b1111);
        check("race_flags", flags(), 32'h1);
        check("race_led", led, 32'd2);
        idle(5);
        check("race_no_tmo", {31'd0, timeout}, 32'd0);
        wr(32'h400, 32'd1, 4'b1111);
        check("boundary_berr", {31'd0, bus_err}, 32'd1);
        rd_chk("boundary_status", STATUS_ADDR, 32'h9);
        rd_chk("boundary_rd", 32'h400, 32'd0);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
